// File: rtl/echo_delay_line_if.sv
// rtl/echo_delay_line_if.sv - sample stream and delay-setting bundle for echo_delay_line
interface echo_delay_line_if #(
  parameter int DATA_W = 12
);
  logic              in_valid;
  logic [DATA_W-1:0] in_sample;
  logic [11:0]       del_ms;
  logic              out_valid;
  logic [DATA_W-1:0] out_sample;
  logic              overrun;

  modport master (
    output in_valid, in_sample, del_ms,
    input  out_valid, out_sample, overrun
  );

  modport slave (
    input  in_valid, in_sample, del_ms,
    output out_valid, out_sample, overrun
  );
endinterface

// File: rtl/echo_delay_line.sv
// rtl/echo_delay_line.sv - echo stage over a circular single-port RAM sample buffer
// Optional ECHO_FEEDBACK_EN: write the mixed output back for a decaying repeated echo.
module echo_delay_line #(
  parameter int DATA_W         = 12,
  parameter int ADDR_W         = 14,
  parameter int SAMPLES_PER_MS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  echo_delay_line_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_MAX = '1;
  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_WRITE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_accept;
  logic                w_overrun;

  logic [11:0]         r_del_ms;
  logic [ADDR_W-1:0]   r_dly;
  logic [DATA_W-1:0]   r_in;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_fill;
  logic [DATA_W-1:0]   r_out;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_rd_data;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic [31:0]         w_dly_full;
  logic [ADDR_W-1:0]   w_dly_clamp;
  logic [ADDR_W-1:0]   w_ram_addr;
  logic                w_ram_we;
  logic                w_ram_re;
  logic [DATA_W-1:0]   w_wet;
  logic signed [DATA_W:0]   w_sum;
  logic signed [DATA_W-1:0] w_mix;
  logic [DATA_W-1:0]   w_wdata;

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_overrun = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_accept = 1'b1;
          w_next   = S_READ;
        end
      end
      S_READ:  w_next = S_WAIT;
      S_WAIT:  w_next = S_WRITE;
      S_WRITE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (bus.in_valid && (r_state != S_IDLE)) begin
      w_overrun = 1'b1;
    end
  end

  assign w_dly_full  = 32'(bus.del_ms) * 32'(SAMPLES_PER_MS);
  assign w_dly_clamp = (w_dly_full > 32'(CNT_MAX)) ? CNT_MAX : w_dly_full[ADDR_W-1:0];

  // One port: read address during S_READ, write address during S_WRITE.
  assign w_ram_we   = (r_state == S_WRITE);
  assign w_ram_re   = (r_state == S_READ);
  assign w_ram_addr = w_ram_we ? r_wr_ptr : (r_wr_ptr - r_dly);

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[w_ram_addr] <= w_wdata;
    end else if (w_ram_re) begin
      r_rd_data <= r_mem[w_ram_addr];
    end
  end

  // Stale RAM (after reset or a delay change) stays masked until the buffer refills.
  assign w_wet = ((r_dly != '0) && (r_fill >= r_dly)) ? r_rd_data : '0;
  assign w_sum = $signed({r_in[DATA_W-1], r_in})
               + $signed({{2{w_wet[DATA_W-1]}}, w_wet[DATA_W-1:1]});

  always_comb begin
    w_mix = w_sum[DATA_W-1:0];
    if (w_sum[DATA_W] != w_sum[DATA_W-1]) begin
      w_mix = w_sum[DATA_W] ? SAT_MIN : SAT_MAX;
    end
  end

`ifdef ECHO_FEEDBACK_EN
  assign w_wdata = w_mix;
`else
  assign w_wdata = r_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_del_ms    <= '0;
      r_dly       <= '0;
      r_in        <= '0;
      r_wr_ptr    <= '0;
      r_fill      <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_out_valid <= 1'b0;
      if (w_accept) begin
        r_in     <= bus.in_sample;
        r_del_ms <= bus.del_ms;
        r_dly    <= w_dly_clamp;
        if (bus.del_ms != r_del_ms) begin
          r_fill <= '0;
        end
      end
      if (r_state == S_WRITE) begin
        r_wr_ptr    <= r_wr_ptr + 1'b1;
        r_out       <= w_mix;
        r_out_valid <= 1'b1;
        if (r_fill != CNT_MAX) begin
          r_fill <= r_fill + 1'b1;
        end
      end
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_sample = r_out;
  assign bus.overrun    = w_overrun;
endmodule

// File: tb/tb_echo_delay_line.sv
// tb/tb_echo_delay_line.sv - scoreboard bench for echo_delay_line (small buffer so wraps are cheap)
module tb_echo_delay_line;
  localparam int DW    = 12;
  localparam int AW    = 10;
  localparam int SPM   = 8;
  localparam int DEPTH = 1 << AW;
  localparam int MAXC  = DEPTH - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  echo_delay_line_if #(.DATA_W(DW)) bus ();

  echo_delay_line #(.DATA_W(DW), .ADDR_W(AW), .SAMPLES_PER_MS(SPM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int obs_log[$];
  int m_mem [DEPTH];
  int m_wp, m_fill, m_del;
  int last_out;

  task automatic check(string tag, int obs, int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  function automatic void model_reset();
    m_wp = 0;
    m_fill = 0;
    m_del = 0;
  endfunction

  function automatic void model(int s, int dms);
    int d, wet, o, w;
    d = dms * SPM;
    if (d > MAXC) d = MAXC;
    if (dms != m_del) begin
      m_fill = 0;
      m_del = dms;
    end
    wet = (d != 0 && m_fill >= d) ? m_mem[(m_wp - d) & MAXC] : 0;
    o = sat(s + (wet >>> 1));
`ifdef ECHO_FEEDBACK_EN
    w = o;
`else
    w = s;
`endif
    m_mem[m_wp] = w;
    m_wp = (m_wp + 1) & MAXC;
    if (m_fill < MAXC) m_fill++;
    exp_q.push_back(o);
  endfunction

  // Entered and left on a falling edge.
  task automatic send(int s, int dms, int gap);
    logic [DW-1:0] sv;
    logic [11:0]   dv;
    sv = s[DW-1:0];
    dv = dms[11:0];
    bus.in_valid  = 1'b1;
    bus.in_sample = sv;
    bus.del_ms    = dv;
    model(s, dms);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic drain();
    repeat (6) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (bus.out_valid) begin
      last_out = int'($signed(bus.out_sample));
      obs_log.push_back(last_out);
      if (exp_q.size() == 0) check("unexpected_out", exp_q.size(), 1);
      else check("sample", last_out, exp_q.pop_front());
    end
  end

  initial begin
    int ins[$];
    int lat;
    int v;
    bus.in_valid  = 1'b0;
    bus.in_sample = '0;
    bus.del_ms    = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_sample", int'(bus.out_sample), 0);
    check("rst_overrun", int'(bus.overrun), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Impulse through an 8-sample echo, one sample per 10 cycles.
    obs_log.delete();
    for (int k = 0; k < 40; k++) send((k == 0) ? 1000 : 0, 1, 9);
    drain();
    check("imp_0", obs_log[0], 1000);
    check("imp_1", obs_log[1], 0);
    check("imp_8", obs_log[8], 500);
`ifdef ECHO_FEEDBACK_EN
    check("imp_16", obs_log[16], 250);
    check("imp_24", obs_log[24], 125);
`else
    check("imp_16", obs_log[16], 0);
`endif

    // Latency: strobe appears on the 4th falling edge after driving.
    bus.in_valid  = 1'b1;
    bus.in_sample = 12'd77;
    bus.del_ms    = 12'd1;
    model(77, 1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) bus.in_valid = 1'b0;
    end while (!bus.out_valid && lat < 10);
    check("latency", lat, 4);
    drain();

    // Delay change 1 -> 2 ms after 100 samples.
    obs_log.delete();
    ins.delete();
    for (int k = 0; k < 140; k++) begin
      v = int'($urandom_range(2000)) - 1000;
      ins.push_back(v);
      send(v, (k < 100) ? 1 : 2, 3);
    end
    drain();
    check("dchg_100", obs_log[100], ins[100]);
    check("dchg_115", obs_log[115], ins[115]);

    // Overrun: second strobe two cycles after an accepted sample.
    bus.in_valid  = 1'b1;
    bus.in_sample = 12'd321;
    bus.del_ms    = 12'd1;
    #1;
    check("ovr_idle", int'(bus.overrun), 0);
    model(321, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_sample = 12'd999;
    #1;
    check("ovr_pulse", int'(bus.overrun), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("ovr_clear", int'(bus.overrun), 0);
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 12; k++) send(k * 10, 1, 3);
    drain();

    // Saturation at both rails.
    for (int k = 0; k < 16; k++) send(0, 1, 3);
    send(2000, 1, 3);
    for (int k = 0; k < 7; k++) send(0, 1, 3);
    send(2000, 1, 3);
    drain();
    check("sat_pos", last_out, 2047);
    send(-2000, 1, 3);
    for (int k = 0; k < 7; k++) send(0, 1, 3);
    send(-2000, 1, 3);
    drain();
    check("sat_neg", last_out, -2048);

    // Reset asserted while the FSM sits in S_WAIT.
    bus.in_valid  = 1'b1;
    bus.in_sample = 12'd500;
    bus.del_ms    = 12'd1;
    model(500, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    model_reset();
    #1;
    check("mid_rst_valid", int'(bus.out_valid), 0);
    check("mid_rst_sample", int'(bus.out_sample), 0);
    check("mid_rst_overrun", int'(bus.overrun), 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(333, 1, 3);
    drain();
    check("post_rst_dry", last_out, 333);

    // Long delay with pointer wraps, then a clamped delay.
    for (int k = 0; k < 2500; k++) send(k % 2048, 100, 3);
    for (int k = 0; k < 1100; k++) send(int'($urandom_range(4000)) - 2000, 200, 3);
    drain();

    repeat (10) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/echo_delay_line.md
# echo_delay_line

Audio echo stage that consumes the 12-bit millisecond delay produced by the effect-settings decoder (echo slot) and applies it to the sample stream. Holds a circular sample buffer in single-port synchronous RAM. Each accepted input sample is mixed with the sample written `delay_samples` samples earlier. Sits between the ADC sample path and the DAC/output mixer.

## Interface
- `DATA_W`, default 12: signed two's-complement sample width.
- `ADDR_W`, default 14: buffer address width; depth is 2^ADDR_W samples.
- `SAMPLES_PER_MS`, default 8: sample rate in samples per millisecond (8 kHz).
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `del_ms`, input, 12: echo delay in ms. A value of 0 disables the wet path.
- `in_valid`, input, 1: one-cycle strobe indicating that `in_sample` is valid.
- `in_sample`, input, DATA_W: signed dry sample.
- `out_valid`, output, 1: one-cycle strobe indicating that `out_sample` is valid.
- `out_sample`, output, DATA_W: signed mixed sample, held between strobes.
- `overrun`, output, 1: one-cycle pulse when `in_valid` arrives while the block is busy.

## Operation
- **Delay capture.** In S_IDLE, when `in_valid` is accepted, `del_ms` is registered.
  - `delay_samples = del_ms * SAMPLES_PER_MS`, computed at full width.
  - The result is clamped to 2^ADDR_W − 1 (with defaults: 1500 ms gives 12000 samples, which is not clamped).
  - If the registered `del_ms` differs from the previously held value, `fill_cnt` clears to 0.
- **FSM states.** S_IDLE → S_READ → S_WAIT → S_WRITE → S_IDLE.
  - **S_IDLE:** waits for `in_valid`; latches `in_sample` and `del_ms`.
  - **S_READ:** drives RAM address `rd_addr = (wr_ptr − delay_samples) mod 2^ADDR_W`. Wrap-around is natural ADDR_W-bit modular subtraction.
  - **S_WAIT:** the RAM data becomes valid at the end of this state.
  - **S_WRITE:** writes the write-data to `wr_ptr`, increments `wr_ptr` (wrapping 2^ADDR_W−1 → 0), registers `out_sample`, and pulses `out_valid`.
- **Wet gating.**
  - `wet = RAM data` only if `delay_samples != 0` and `fill_cnt >= delay_samples`; otherwise `wet = 0`.
  - `fill_cnt` increments once per write and saturates at 2^ADDR_W − 1.
- **Mix.**
  - `out_sample = sat(in + (wet >>> 1))`, computed at DATA_W+1 bits.
  - Saturation limits are +2^(DATA_W−1)−1 and −2^(DATA_W−1).
- **Write data.** The latched `in_sample` (but see Configuration).
- **Busy input.** `in_valid` in any state other than S_IDLE is dropped, and `overrun` pulses in that same cycle. State is unaffected.
- **Same-address case.** If `delay_samples == 0`, no read hazard is possible: the wet path is forced to 0.

## Timing
- **Reset values:** `out_valid = 0`, `out_sample = 0`, `overrun = 0`, FSM = S_IDLE, `wr_ptr = 0`, `fill_cnt = 0`, held `del_ms = 0`.
- **Reset mid-operation:** an async assert aborts any state immediately with no write. RAM contents are not cleared; `fill_cnt = 0` masks stale data.
- **Latency:** if `in_valid` is high at edge N, `out_valid` is high in the cycle after edge N+3. That is, 3 cycles of latency, one sample per 4 cycles maximum throughput.
- **Back-to-back input:** the earliest accepted next `in_valid` is 4 cycles after the previous one.
- **`del_ms` changes:** may change at any time; they are only observed on sample acceptance.

## Configuration
- **`ECHO_FEEDBACK_EN` defined:** write-data = `sat(in + (wet >>> 1))`, i.e. the mixed output is written back. This gives a decaying repeated echo.
- **`ECHO_FEEDBACK_EN` not defined:** write-data = the dry `in_sample`, giving a single echo. All timing is identical in both cases.

## Test plan
- **Reset:** assert `rst_n = 0` mid-S_WAIT → all outputs are 0, no `out_valid`, and the next sample after release yields `out_sample == in_sample`.
- **Basic echo:** `del_ms = 1` (8 samples); feed impulse 1000 followed by zeros at one sample per 10 cycles.
  - Output sample 0 = 1000 and output sample 8 = 500; all others = 0.
  - With `ECHO_FEEDBACK_EN`, output sample 16 = 250 and output sample 24 = 125.
- **Wrap and long delay:** `del_ms = 1500`; stream 20000 ramp samples `k mod 2048` → output k = `sat(k mod 2048 + ((k − 12000) mod 2048 >>> 1))` for k ≥ 12000, with no glitch at the `wr_ptr` wrap at 16384.
- **Delay change:** switch `del_ms` from 1 to 2 after 100 samples → wet = 0 for the next 16 samples, after which the echo appears 16 samples back.
- **Saturation and overrun:**
  - Saturation: `in = 2000` with wet source 2000 → `out_sample = 2047`; `in = −2000` with wet source −2000 → `out_sample = −2048`.
  - Overrun: `in_valid` asserted 2 cycles after an accepted sample → `overrun` pulses, the sample is dropped, and `wr_ptr` advances only once.
